// File: rtl/warped_frame_streamer.sv
// Streams one warped frame out of BRAM as an AXI-Stream video beat sequence.
// A 2-entry skid FIFO absorbs the 1-cycle BRAM latency so backpressure never drops data.
module warped_frame_streamer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_re,
    input  logic [PIXEL_WIDTH-1:0] rd_data,
    output logic [PIXEL_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   m_tuser
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | issuing reads and emitting beats
    // FINISH | one-cycle done pulse, then back to IDLE

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                 state;
    logic                   reads_done;
    logic                   pend;
    logic [PIXEL_WIDTH-1:0] fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;
    logic [XW-1:0]          out_x;
    logic [YW-1:0]          out_y;
    logic                   push;
    logic                   pop;
    logic                   last_beat;
    logic [2:0]             committed;

    assign push      = pend;
    assign pop       = m_tvalid && m_tready;
    assign last_beat = pop && (out_x == X_LAST) && (out_y == Y_LAST);

    // Credit check counts the slot freed by this cycle's pop, which is what
    // lets a 2-entry FIFO sustain one beat per cycle across the read latency.
    assign committed = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, pend};
    assign rd_re     = (state == STREAM) && !reads_done && (committed < 3'd2);

    assign m_tvalid = (fifo_cnt != 2'd0);
    assign m_tdata  = fifo_mem[rd_ptr];
    assign m_tlast  = m_tvalid && (out_x == X_LAST);
    assign m_tuser  = m_tvalid && (out_x == '0) && (out_y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last_beat) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            reads_done <= 1'b0;
            pend       <= 1'b0;
        end else begin
            pend <= rd_re;
            if ((state == IDLE) && start) begin
                rd_addr    <= '0;
                reads_done <= 1'b0;
            end else if (rd_re) begin
                if (rd_addr == LAST_ADDR) begin
                    reads_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x <= '0;
            out_y <= '0;
        end else if (state == IDLE) begin
            out_x <= '0;
            out_y <= '0;
        end else if (pop) begin
            if (out_x == X_LAST) begin
                out_x <= '0;
                out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
            end else begin
                out_x <= out_x + 1'b1;
            end
        end
    end

endmodule

// File: doc/warped_frame_streamer.md
WARPED_FRAME_STREAMER -- requirements
Module: warped_frame_streamer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter WIDTH, default 160, frame width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 120, frame height in lines.
REQ-004 SHALL have parameter ADDR_WIDTH, default 17, BRAM address width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port start  input  1  begin streaming one frame; sampled only in IDLE.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port rd_addr  output  ADDR_WIDTH  warped-frame BRAM read address.
REQ-011 SHALL have port rd_re  output  1  BRAM read enable.
REQ-012 SHALL have port rd_data  input  PIXEL_WIDTH  BRAM read data, valid exactly 1 cycle after rd_re.
REQ-013 SHALL have port m_tdata  output  PIXEL_WIDTH  streamed pixel.
REQ-014 SHALL have port m_tvalid  output  1  m_tdata valid.
REQ-015 SHALL have port m_tready  input  1  downstream accept.
REQ-016 SHALL have port m_tlast  output  1  end of line (x == WIDTH-1).
REQ-017 SHALL have port m_tuser  output  1  start of frame (pixel 0,0).

Function
REQ-018 SHALL implement FSM states IDLE, STREAM, FINISH; IDLE->STREAM on start; STREAM->FINISH when the last beat handshakes; FINISH->IDLE unconditionally after one cycle.
REQ-019 SHALL drive done=1 only in FINISH, for exactly one cycle.
REQ-020 SHALL ignore start in STREAM and FINISH.
REQ-021 SHALL read addresses 0..WIDTH*HEIGHT-1 in ascending raster order, each exactly once per frame, rd_addr = y*WIDTH + x via an incrementing linear counter (no multiplier).
REQ-022 SHALL issue the read for address 0 (rd_re=1) in the first STREAM cycle.
REQ-023 SHALL buffer returned data in a 2-entry FIFO and issue a read only when (FIFO occupancy + reads in flight) < 2, so no BRAM data is ever dropped under backpressure.
REQ-024 SHALL write rd_data into the FIFO on the cycle after the corresponding rd_re.
REQ-025 SHALL assert m_tvalid whenever the FIFO is non-empty; first m_tvalid appears 2 cycles after rd_re for address 0.
REQ-026 SHALL hold m_tdata, m_tlast and m_tuser stable while m_tvalid=1 and m_tready=0.
REQ-027 SHALL count a beat only when m_tvalid and m_tready are both 1 in a cycle.
REQ-028 SHALL sustain one beat per cycle when m_tready is held 1.
REQ-029 SHALL attach m_tlast/m_tuser per beat from output-side x/y counters, x wrapping WIDTH-1->0 with y incremented.
REQ-030 SHALL stop issuing reads after address WIDTH*HEIGHT-1 and keep rd_re=0 outside STREAM.
REQ-031 SHALL handle simultaneous FIFO push and pop without occupancy change or data loss.

Reset
REQ-032 SHALL, on rst=1, asynchronously force state=IDLE, busy=0, done=0, rd_re=0, rd_addr=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, FIFO empty, all counters 0.
REQ-033 SHALL, on reset asserted mid-frame, discard in-flight reads and buffered pixels; after release, wait in IDLE for a new start.

Verification
REQ-034 SHALL cover: BRAM preloaded with addr mod 256, start pulse, m_tready=1 -> 19200 beats in order, data addr mod 256, first m_tvalid 2 cycles after first rd_re, one beat per cycle, done pulse once.
REQ-035 SHALL cover: m_tready random 50% -> identical data sequence, no duplicate or missing beat, m_tdata stable during every stall, at most 2 reads outstanding+buffered.
REQ-036 SHALL cover: framing checks -> m_tuser only on beat 0; m_tlast on beats 159, 319, ..., 19199 (120 total).
REQ-037 SHALL cover: m_tready=0 for 100 cycles after start -> exactly 2 rd_re issued, m_tvalid stays 1 with pixel 0; release -> stream resumes correctly.
REQ-038 SHALL cover: rst pulsed at beat 5000, then new start -> all outputs at reset values immediately, new frame begins at address 0 with m_tuser=1.
REQ-039 SHALL cover: start held high across a full frame -> second start ignored until IDLE, then second frame streams identically.
